// File: rtl/boot_loader_pkg.sv
// Shared constants and types for the boot loader: FSM encodings, widths, bus payloads.
package boot_loader_pkg;

  localparam int unsigned CHK_WIDTH      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned STATE_W        = 3;

  localparam logic [STATE_W-1:0] S_CNT_HI = 3'd0;
  localparam logic [STATE_W-1:0] S_CNT_LO = 3'd1;
  localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
  localparam logic [STATE_W-1:0] S_CHECK  = 3'd3;
  localparam logic [STATE_W-1:0] S_RUN    = 3'd4;
  localparam logic [STATE_W-1:0] S_ERROR  = 3'd5;

  // One instruction-memory write: byte address plus assembled word.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } imem_wr_t;

  // States in which the loader is willing to take a byte.
  function automatic logic is_rx_state(input logic [STATE_W-1:0] s);
    return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_DATA) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface boot_loader_if;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  // Stream source / memory sink side.
  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/boot_loader_byte_assembler.sv
// Big-endian byte-to-word assembler: first byte lands in bits [31:24].
module boot_loader_byte_assembler
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o,
  output logic        last_byte_c_o
);

  localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD);
  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD;
  localparam int unsigned SHR_W  = WORD_W - 8;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SHR_W-1:0]  shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              done_q, done_d;

  // Shift in bytes; on the last byte of a word publish it with a one-cycle done pulse.
  always_comb begin
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    word_d        = word_q;
    done_d        = 1'b0;
    last_byte_c_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      if (last_byte_c_o) begin
        word_d  = {shift_q, byte_i};
        done_d  = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        shift_d = {shift_q[SHR_W-9:0], byte_i};
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = done_q;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: streams a length-prefixed, checksummed program into instruction
// memory and holds the core in reset until the checksum verifies.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned          ADDR_WORDS_LOG2 = 8,
  parameter logic [CHK_WIDTH-1:0] CHK_INIT        = 8'h00
) (
  input  logic                     clk,
  input  logic                     reset,
  boot_loader_if.slave             bus,
  input  logic                     restart,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error,
  output logic [ADDR_WORDS_LOG2:0] words_loaded
);

  localparam int unsigned CNT_W     = ADDR_WORDS_LOG2 + 1;
  localparam int unsigned MAX_WORDS = 32'(1) << ADDR_WORDS_LOG2;

  logic [STATE_W-1:0]   state_q, state_d;
  logic [15:0]          n_q, n_d;
  logic [CHK_WIDTH-1:0] chk_q, chk_d;
  logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic [31:0]          waddr_q, waddr_d;
  logic                 in_ready_q, in_ready_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  logic                 accept;
  logic                 data_byte_valid;
  logic                 asm_clear;
  logic                 last_byte;
  logic                 asm_done;
  logic [31:0]          asm_word;
  logic [CNT_W-1:0]     word_cnt_inc;

  assign accept          = bus.in_valid && in_ready_q;
  assign data_byte_valid = accept && (state_q == S_DATA);
  assign word_cnt_inc    = word_cnt_q + CNT_W'(1);

  boot_loader_byte_assembler u_asm (
    .clk           (clk),
    .rst_n         (reset),
    .clear_i       (asm_clear),
    .byte_valid_i  (data_byte_valid),
    .byte_i        (bus.in_data),
    .word_o        (asm_word),
    .word_done_o   (asm_done),
    .last_byte_c_o (last_byte)
  );

  // Next-state, checksum, address generation and registered output decode.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    chk_d      = chk_q;
    word_cnt_d = word_cnt_q;
    waddr_d    = waddr_q;
    asm_clear  = 1'b0;

    case (state_q)
      S_CNT_HI: begin
        if (accept) begin
          n_d     = {bus.in_data, n_q[7:0]};
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          n_d = {n_q[15:8], bus.in_data};
          if (32'(n_d) > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (n_d == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d = chk_q + bus.in_data;
          // Address is latched alongside the word so both appear with the write pulse.
          if (last_byte) begin
            waddr_d    = 32'({word_cnt_q, 2'b00});
            word_cnt_d = word_cnt_inc;
            if (32'(word_cnt_inc) == 32'(n_q)) begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (bus.in_data == chk_q) ? S_RUN : S_ERROR;
        end
      end
      S_RUN, S_ERROR: begin
        if (restart) begin
          state_d    = S_CNT_HI;
          n_d        = '0;
          chk_d      = CHK_INIT;
          word_cnt_d = '0;
          asm_clear  = 1'b1;
        end
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    in_ready_d  = is_rx_state(state_d);
    done_d      = (state_d == S_RUN);
    error_d     = (state_d == S_ERROR);
    // Core leaves reset one cycle after S_RUN is entered; a restart re-asserts it at once.
    cpu_reset_d = !((state_q == S_RUN) && (state_d == S_RUN));
  end

  // Loader state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_CNT_HI;
      n_q         <= '0;
      chk_q       <= CHK_INIT;
      word_cnt_q  <= '0;
      waddr_q     <= '0;
      in_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      chk_q       <= chk_d;
      word_cnt_q  <= word_cnt_d;
      waddr_q     <= waddr_d;
      in_ready_q  <= in_ready_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = asm_done;
  assign bus.imem_wdata = asm_word;
  assign bus.imem_waddr = waddr_q;
  assign cpu_reset      = cpu_reset_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = word_cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued as stimulus
// is issued, and a negedge monitor pops and compares each imem_we pulse.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          restart;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int            checks = 0;
  int            errors = 0;
  imem_wr_t      exp_q[$];
  logic [31:0]   last_addr = 32'hFFFF_FFFF;

  boot_loader_if bus();

  boot_loader #(
    .ADDR_WORDS_LOG2 (AW),
    .CHK_INIT        (8'h00)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .restart      (restart),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic imem_wr_t mk_wr(input logic [31:0] a, input logic [31:0] d);
    imem_wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    imem_wr_t e;
    if (reset && bus.imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h with nothing expected",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL imem_write: got addr=%h data=%h expected addr=%h data=%h",
                   bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
        end
      end
      last_addr = bus.imem_waddr;
    end
  end

  // Present one byte (after 'gap' idle cycles) and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed %b for byte %h, expected 1", bus.in_ready, b);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) send_byte(s[i], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},     32'(bus.in_ready),   32'd1);
    chk({tag, "_cpu_reset"},    32'(cpu_reset),      32'd1);
    chk({tag, "_imem_we"},      32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_waddr"},   bus.imem_waddr,      32'd0);
    chk({tag, "_imem_wdata"},   bus.imem_wdata,      32'd0);
    chk({tag, "_done"},         32'(done),           32'd0);
    chk({tag, "_error"},        32'(error),          32'd0);
    chk({tag, "_words_loaded"}, 32'(words_loaded),   32'd0);
  endtask

  task automatic push_two_words();
    exp_q.push_back(mk_wr(32'h0, 32'hDEAD_BEEF));
    exp_q.push_back(mk_wr(32'h4, 32'h0000_0001));
  endtask

  // Bound on total simulated time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    // Data bytes DE+AD+BE+EF+00+00+00+01 = 0x339, so the mod-256 checksum is 0x39.
    logic [7:0] s_good[$];
    logic [7:0] s_bad[$];
    logic [7:0] s_rest[$];
    logic [7:0] s_big[$];
    logic [7:0] sum;
    logic [7:0] b0, b1, b2, b3;

    s_good = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h39};
    s_bad  = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7F};
    s_rest = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h39};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    restart      = 1'b0;
    reset        = 1'b0;
    #12;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Two-word load with a good checksum.
    push_two_words();
    send_stream(s_good, 1'b0);
    chk("t1_done",           32'(done),         32'd1);
    chk("t1_cpu_reset_hold", 32'(cpu_reset),    32'd1);
    chk("t1_words_loaded",   32'(words_loaded), 32'd2);
    chk("t1_in_ready",       32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t1_cpu_reset_low",  32'(cpu_reset),    32'd0);
    chk("t1_drain",          32'(exp_q.size()), 32'd0);

    pulse_restart();
    chk("rs1_in_ready",      32'(bus.in_ready), 32'd1);
    chk("rs1_cpu_reset",     32'(cpu_reset),    32'd1);
    chk("rs1_done",          32'(done),         32'd0);
    chk("rs1_words_loaded",  32'(words_loaded), 32'd0);

    // Same program with a bad checksum.
    push_two_words();
    send_stream(s_bad, 1'b0);
    chk("t2_error",          32'(error),        32'd1);
    chk("t2_cpu_reset",      32'(cpu_reset),    32'd1);
    chk("t2_in_ready",       32'(bus.in_ready), 32'd0);
    chk("t2_done",           32'(done),         32'd0);

    // A byte offered while not ready is neither consumed nor changes state.
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t2_err_sticky",     32'(error),        32'd1);
    chk("t2_wl_hold",        32'(words_loaded), 32'd2);

    pulse_restart();
    chk("rs2_error",         32'(error),        32'd0);
    chk("rs2_in_ready",      32'(bus.in_ready), 32'd1);

    // Reload; a restart pulse mid-count must be ignored.
    push_two_words();
    send_byte(8'h00, 0);
    pulse_restart();
    send_stream(s_rest, 1'b0);
    chk("t2b_done",          32'(done),         32'd1);
    chk("t2b_error",         32'(error),        32'd0);
    chk("t2b_drain",         32'(exp_q.size()), 32'd0);

    // Empty program.
    pulse_restart();
    send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
    chk("t3_done",           32'(done),         32'd1);
    chk("t3_words_loaded",   32'(words_loaded), 32'd0);

    // Count 0x101 exceeds 256 words.
    pulse_restart();
    send_stream('{8'h01, 8'h01}, 1'b0);
    chk("t4_error",          32'(error),        32'd1);
    chk("t4_in_ready",       32'(bus.in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_words_loaded",   32'(words_loaded), 32'd0);

    // Full 256-word program with random idle gaps; checksum wraps many times.
    pulse_restart();
    sum = 8'h00;
    s_big = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i);
      b1 = 8'(i + 1);
      b2 = 8'(i * 3);
      b3 = 8'hC3;
      exp_q.push_back(mk_wr(32'(i * 4), {b0, b1, b2, b3}));
      s_big.push_back(b0);
      s_big.push_back(b1);
      s_big.push_back(b2);
      s_big.push_back(b3);
      sum = sum + b0 + b1 + b2 + b3;
    end
    s_big.push_back(sum);
    send_stream(s_big, 1'b1);
    chk("t5_done",           32'(done),         32'd1);
    chk("t5_words_loaded",   32'(words_loaded), 32'd256);
    chk("t5_last_addr",      last_addr,         32'h0000_03FC);
    chk("t5_drain",          32'(exp_q.size()), 32'd0);

    // Reset dropped after six data bytes abandons the load.
    pulse_restart();
    exp_q.push_back(mk_wr(32'h0, 32'h1122_3344));
    send_stream('{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}, 1'b0);
    chk("t6_wl_before",      32'(words_loaded), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    @(posedge clk);
    #1;
    reset = 1'b1;
    push_two_words();
    send_stream(s_good, 1'b0);
    chk("t6_done",           32'(done),         32'd1);
    chk("t6_words_loaded",   32'(words_loaded), 32'd2);
    chk("t6_drain",          32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
